// File: rtl/exe_stage_unit.sv
// rtl/exe_stage_unit.sv - execute stage: ALU, NZCV status, branch target, EX/MEM register
module exe_stage_unit #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic [3:0]        exe_command,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic              write_back_enable,
    input  logic              branch,
    input  logic              status_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [IMM_W-1:0]  signed_imm,
    input  logic [3:0]        dest,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [3:0]        dest_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out,
    output logic [3:0]        status_reg,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr
);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;

    localparam int SEXT_W = DATA_W - IMM_W - 2;

    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] val_rm_q;
    logic [3:0]        dest_q;
    logic              mem_r_en_q;
    logic              mem_w_en_q;
    logic              wb_en_q;
    logic [3:0]        status_q;
    logic [3:0]        status_d;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum_ext;
    logic              carry_in;
    logic              is_arith;
    logic              flag_ok;
    logic              ovf;
    logic              c_flag;

    assign c_flag = status_q[1];

    // Subtraction reuses the adder as rn + ~val2 + cin, so carry out is NOT borrow.
    always_comb begin
        op_b     = val2;
        carry_in = 1'b0;
        is_arith = 1'b0;
        case (exe_command)
            OP_ADD: is_arith = 1'b1;
            OP_ADC: begin
                is_arith = 1'b1;
                carry_in = c_flag;
            end
            OP_SUB: begin
                is_arith = 1'b1;
                op_b     = ~val2;
                carry_in = 1'b1;
            end
            OP_SBC: begin
                is_arith = 1'b1;
                op_b     = ~val2;
                carry_in = c_flag;
            end
            default: ;
        endcase
        sum_ext = {1'b0, val_rn} + {1'b0, op_b} + {{DATA_W{1'b0}}, carry_in};
    end

    always_comb begin
        alu_res = '0;
        flag_ok = 1'b1;
        case (exe_command)
            OP_MOV:                         alu_res = val2;
            OP_MVN:                         alu_res = ~val2;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: alu_res = sum_ext[DATA_W-1:0];
            OP_AND:                         alu_res = val_rn & val2;
            OP_ORR:                         alu_res = val_rn | val2;
            OP_EOR:                         alu_res = val_rn ^ val2;
            default:                        flag_ok = 1'b0;
        endcase
    end

    assign ovf = (val_rn[DATA_W-1] == op_b[DATA_W-1]) &&
                 (alu_res[DATA_W-1] != val_rn[DATA_W-1]);

    always_comb begin
        status_d = status_q;
        if (status_in && flag_ok) begin
            status_d[3] = alu_res[DATA_W-1];
            status_d[2] = (alu_res == '0);
            if (is_arith) begin
                status_d[1] = sum_ext[DATA_W];
                status_d[0] = ovf;
            end
        end
    end

    // Flush outranks freeze so a squashed instruction always leaves a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            val_rm_q     <= '0;
            dest_q       <= '0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            status_q     <= '0;
        end else if (flush) begin
            alu_result_q <= alu_res;
            val_rm_q     <= val_rm;
            dest_q       <= dest;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            wb_en_q      <= 1'b0;
        end else if (!freeze) begin
            alu_result_q <= alu_res;
            val_rm_q     <= val_rm;
            dest_q       <= dest;
            mem_r_en_q   <= mem_read_enable;
            mem_w_en_q   <= mem_write_enable;
            wb_en_q      <= write_back_enable;
            status_q     <= status_d;
        end
    end

    assign alu_result_out = alu_result_q;
    assign val_rm_out     = val_rm_q;
    assign dest_out       = dest_q;
    assign mem_r_en_out   = mem_r_en_q;
    assign mem_w_en_out   = mem_w_en_q;
    assign wb_en_out      = wb_en_q;
    assign status_reg     = status_q;

    assign branch_addr  = pc_in + {{SEXT_W{signed_imm[IMM_W-1]}}, signed_imm, 2'b00};
    assign branch_taken = branch & ~flush;

endmodule

// File: tb/tb_exe_stage_unit.sv
// tb/tb_exe_stage_unit.sv - randomized bench for exe_stage_unit against an arithmetic model
module tb_exe_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush;
    logic [3:0]  exe_command;
    logic        mem_read_enable, mem_write_enable, write_back_enable;
    logic        branch, status_in;
    logic [31:0] pc_in, val_rn, val2, val_rm;
    logic [23:0] signed_imm;
    logic [3:0]  dest;
    logic [31:0] alu_result_out, val_rm_out, branch_addr;
    logic [3:0]  dest_out, status_reg;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, branch_taken;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    exe_stage_unit #(.DATA_W(32), .IMM_W(24)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .exe_command(exe_command), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .write_back_enable(write_back_enable),
        .branch(branch), .status_in(status_in), .pc_in(pc_in), .val_rn(val_rn),
        .val2(val2), .val_rm(val_rm), .signed_imm(signed_imm), .dest(dest),
        .alu_result_out(alu_result_out), .val_rm_out(val_rm_out), .dest_out(dest_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
        .status_reg(status_reg), .branch_taken(branch_taken), .branch_addr(branch_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: wide signed/unsigned integer arithmetic on the operation's meaning.
    function automatic void alu_model(input logic [3:0] cmd, input logic [31:0] rn,
                                      input logic [31:0] v2, input logic [3:0] nzcv_in,
                                      input bit s, output logic [31:0] res,
                                      output logic [3:0] nzcv_out);
        longint a, b, sa, sb, full, sfull, cin;
        bit arith, sub, valid, c, v;
        a = longint'(rn); b = longint'(v2);
        sa = longint'($signed(rn)); sb = longint'($signed(v2));
        cin = longint'(nzcv_in[1]);
        arith = 0; sub = 0; valid = 1; full = 0; sfull = 0; res = 0;
        case (cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd6: res = rn & v2;
            4'd7: res = rn | v2;
            4'd8: res = rn ^ v2;
            4'd2: begin arith = 1; full = a + b;       sfull = sa + sb; end
            4'd3: begin arith = 1; full = a + b + cin; sfull = sa + sb + cin; end
            4'd4: begin arith = 1; sub = 1; full = a - b;             sfull = sa - sb; end
            4'd5: begin arith = 1; sub = 1; full = a - b - (1 - cin); sfull = sa - sb - (1 - cin); end
            default: valid = 0;
        endcase
        if (arith) res = full[31:0];
        c = sub ? (full >= 0) : (full > 64'h0000_0000_FFFF_FFFF);
        v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
        nzcv_out = nzcv_in;
        if (s && valid) begin
            nzcv_out[3] = res[31];
            nzcv_out[2] = (res == 0);
            if (arith) begin
                nzcv_out[1] = c;
                nzcv_out[0] = v;
            end
        end
    endfunction

    logic [31:0] m_res, m_rm;
    logic [3:0]  m_dest, m_nzcv;
    logic        m_mr, m_mw, m_wb, m_bubble;
    logic [31:0] t_res;
    logic [3:0]  t_nzcv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_res <= 0; m_rm <= 0; m_dest <= 0; m_nzcv <= 0;
            m_mr <= 0; m_mw <= 0; m_wb <= 0; m_bubble <= 0;
        end else if (flush) begin
            m_mr <= 0; m_mw <= 0; m_wb <= 0; m_bubble <= 1;
        end else if (!freeze) begin
            alu_model(exe_command, val_rn, val2, m_nzcv, status_in, t_res, t_nzcv);
            m_res <= t_res; m_rm <= val_rm; m_dest <= dest; m_nzcv <= t_nzcv;
            m_mr <= mem_read_enable; m_mw <= mem_write_enable; m_wb <= write_back_enable;
            m_bubble <= 0;
        end
    end

    logic [31:0] e_baddr;
    always @(negedge clk) begin
        if (cmp_en) begin
            if (!m_bubble) begin
                chk("alu_result_out", alu_result_out, m_res);
                chk("val_rm_out", val_rm_out, m_rm);
                chk("dest_out", {28'd0, dest_out}, {28'd0, m_dest});
            end
            chk("mem_r_en_out", {31'd0, mem_r_en_out}, {31'd0, m_mr});
            chk("mem_w_en_out", {31'd0, mem_w_en_out}, {31'd0, m_mw});
            chk("wb_en_out", {31'd0, wb_en_out}, {31'd0, m_wb});
            chk("status_reg", {28'd0, status_reg}, {28'd0, m_nzcv});
            e_baddr = 32'(longint'(pc_in) + longint'($signed(signed_imm)) * 4);
            chk("branch_addr", branch_addr, e_baddr);
            chk("branch_taken", {31'd0, branch_taken}, {31'd0, branch & ~flush});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                          input bit s, input bit wb);
        exe_command = cmd; val_rn = rn; val2 = v2; status_in = s; write_back_enable = wb;
        mem_read_enable = 0; mem_write_enable = 0; branch = 0; freeze = 0; flush = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1; freeze = 0; flush = 0; branch = 0; status_in = 0;
        exe_command = 0; mem_read_enable = 0; mem_write_enable = 0; write_back_enable = 0;
        pc_in = 0; val_rn = 0; val2 = 0; val_rm = 32'hDEAD_BEEF; signed_imm = 0; dest = 4'd1;
        tick(); tick();
        chk("reset_alu", alu_result_out, 32'h0);
        chk("reset_status", {28'd0, status_reg}, 32'h0);
        rst = 0;
        cmp_en = 1;

        set_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 1); tick();
        chk("add_ovf_res", alu_result_out, 32'h8000_0000);
        chk("add_ovf_nzcv", {28'd0, status_reg}, 32'h9);

        set_op(4'b0100, 32'd5, 32'd5, 1, 0); tick();
        chk("cmp_nzcv", {28'd0, status_reg}, 32'h6);
        chk("cmp_wb", {31'd0, wb_en_out}, 32'h0);
        set_op(4'b0001, 32'h0, 32'h1234, 0, 1); tick();
        chk("mov_nzcv_hold", {28'd0, status_reg}, 32'h6);
        chk("mov_res", alu_result_out, 32'h1234);

        set_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 1, 1); tick();
        chk("carry_res", alu_result_out, 32'h0);
        chk("carry_nzcv", {28'd0, status_reg}, 32'h6);
        set_op(4'b0011, 32'd1, 32'd1, 0, 1); tick();
        chk("adc_res", alu_result_out, 32'd3);
        set_op(4'b0010, 32'd1, 32'd1, 1, 1); tick();
        chk("clear_c_nzcv", {28'd0, status_reg}, 32'h0);
        set_op(4'b0101, 32'd5, 32'd2, 0, 1); tick();
        chk("sbc_res", alu_result_out, 32'd2);

        pc_in = 32'h100; signed_imm = 24'hFF_FFFE; branch = 1; #1;
        chk("br_taken", {31'd0, branch_taken}, 32'h1);
        chk("br_addr", branch_addr, 32'hF8);
        flush = 1; #1;
        chk("br_flush", {31'd0, branch_taken}, 32'h0);
        flush = 0; branch = 0;

        set_op(4'b0010, 32'h8000_0000, 32'h10, 1, 1); mem_read_enable = 1; dest = 4'd3; tick();
        chk("ldr_res", alu_result_out, 32'h8000_0010);
        chk("ldr_nzcv", {28'd0, status_reg}, 32'h8);
        set_op(4'b0100, 32'd5, 32'd5, 1, 0); freeze = 1; dest = 4'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_res", alu_result_out, 32'h8000_0010);
            chk("frz_dest", {28'd0, dest_out}, 32'h3);
            chk("frz_mr", {31'd0, mem_r_en_out}, 32'h1);
            chk("frz_nzcv", {28'd0, status_reg}, 32'h8);
        end
        set_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 1, 1); mem_read_enable = 1; freeze = 1; flush = 1; tick();
        chk("fl_mr", {31'd0, mem_r_en_out}, 32'h0);
        chk("fl_wb", {31'd0, wb_en_out}, 32'h0);
        chk("fl_nzcv", {28'd0, status_reg}, 32'h8);

        set_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 1); mem_write_enable = 1; tick();
        chk("pre_rst_res", alu_result_out, 32'h8000_0000);
        #2 rst = 1; #1;
        chk("arst_res", alu_result_out, 32'h0);
        chk("arst_rm", val_rm_out, 32'h0);
        chk("arst_en", {29'd0, mem_r_en_out, mem_w_en_out, wb_en_out}, 32'h0);
        chk("arst_nzcv", {28'd0, status_reg}, 32'h0);
        tick(); rst = 0;

        for (int n = 0; n < 2000; n++) begin
            exe_command = 4'($urandom_range(0, 15));
            val_rn = pick(); val2 = pick(); val_rm = $urandom;
            status_in = 1'($urandom_range(0, 1));
            mem_read_enable = 1'($urandom_range(0, 1));
            mem_write_enable = 1'($urandom_range(0, 1));
            write_back_enable = 1'($urandom_range(0, 1));
            branch = 1'($urandom_range(0, 1));
            pc_in = $urandom; signed_imm = 24'($urandom);
            dest = 4'($urandom_range(0, 15));
            freeze = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 9) == 0);
            tick();
            if (rst) rst = 0;
            else if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1;
            end
        end
        rst = 0;
        tick();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_stage_unit.md
Name: exe_stage_unit

Overview:
Execute stage of the pipelined ARM-subset core. It consumes the decoded control bundle (exe_command, memory enables, write-back enable, branch, S bit) and performs the ALU operation. It owns the NZCV status register, computes the branch target, and registers results into the EX/MEM pipeline register. Freeze (stall) and flush (squash) inputs come from the hazard/branch logic.

Parameters:
DATA_W, 32, datapath width for operands and result
IMM_W, 24, branch immediate width (word offset)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
freeze  in  1  hold EX/MEM register and status register
flush  in  1  squash current instruction (insert bubble)
exe_command  in  4  ALU operation code from decode
mem_read_enable  in  1  load instruction
mem_write_enable  in  1  store instruction
write_back_enable  in  1  instruction writes Rd
branch  in  1  branch instruction (condition already resolved upstream)
status_in  in  1  S bit: update NZCV
pc_in  in  DATA_W  PC+4 of the instruction in EX
val_rn  in  DATA_W  first operand
val2  in  DATA_W  shifter/immediate operand
val_rm  in  DATA_W  store data
signed_imm  in  IMM_W  branch offset, two's complement words
dest  in  4  destination register index
alu_result_out  out  DATA_W  registered ALU result / memory address
val_rm_out  out  DATA_W  registered store data
dest_out  out  4  registered destination
mem_r_en_out, mem_w_en_out, wb_en_out  out  1 each  registered enables
status_reg  out  4  NZCV, bit3=N … bit0=V
branch_taken  out  1  combinational, to fetch
branch_addr  out  DATA_W  combinational branch target

Behaviour:
- Reset (async, any time incl. mid-instruction): all registered outputs and status_reg = 0 immediately; held until rst deasserts.
- ALU (combinational, C = status_reg[1]):
  - 0001 MOV: val2
  - 1001 MVN: ~val2
  - 0010 ADD: rn+val2
  - 0011 ADC: rn+val2+C
  - 0100 SUB: rn−val2
  - 0101 SBC: rn−val2−(~C)
  - 0110 AND, 0111 ORR, 1000 EOR
  - any other code: result 0, no flag update.
- Flags when status_in=1:
  - N = result[DATA_W−1]; Z = (result==0).
  - Arithmetic ops: C = carry out of the DATA_W+1-bit sum; for SUB/SBC, C = NOT borrow (rn≥val2 on SUB gives C=1). V = signed overflow.
  - Logical/MOV/MVN: C and V unchanged.
- Latency: one cycle. Inputs at edge k appear on the *_out ports after edge k. status_reg updates at the same edge, so the next instruction's ADC/SBC sees the new C (no forwarding needed).
- Branch: branch_addr = pc_in + (sign_extend(signed_imm) << 2), modulo 2^DATA_W. branch_taken = branch & ~flush.
- Edge priority:
  - rst
  - flush: EX/MEM enables captured as 0, data fields don't-care, status_reg not updated.
  - freeze: all registers and status_reg hold.
  - otherwise: normal capture.
- Simultaneous flush and freeze: flush wins (bubble inserted).
- CMP/TST arrive with write_back_enable=0 and are passed through unchanged; only status_reg changes.

Test Plan:
- ADD overflow: rn=0x7FFFFFFF, val2=1, cmd 0010, S=1 → alu_result_out=0x80000000, status_reg=4'b1001 after one edge.
- CMP equal: rn=5, val2=5, cmd 0100, wb=0, S=1 → status_reg=4'b0110, wb_en_out=0; then MOV with S=0 → status_reg unchanged.
- Carry chain: ADD 0xFFFFFFFF+1, S=1 → result 0, NZCV=0110; next cycle ADC rn=1, val2=1 → result 3. SBC rn=5, val2=2 with C=0 → result 2.
- Branch: pc_in=0x100, signed_imm=0xFFFFFE, branch=1 → branch_taken=1 and branch_addr=0xF8 in the same cycle; with flush=1 → branch_taken=0.
- Freeze/flush: LDR (mem_r=1, wb=1) under freeze=1 for 3 cycles → outputs hold previous values. With flush=1 → mem_r_en_out=wb_en_out=0 and status_reg unchanged even with S=1.
- Async reset mid-stream: assert rst between edges while outputs are non-zero → all outputs and status_reg go to 0 before the next edge.
